// File: rtl/snake_pkg.sv
// Shared direction encoding for the keyboard decode, turn buffer and snake field stages.
package snake_pkg;

  localparam int unsigned DIR_W = 2;

  typedef logic [DIR_W-1:0] dir_t;

  localparam dir_t DIR_UP    = 2'd0;
  localparam dir_t DIR_RIGHT = 2'd1;
  localparam dir_t DIR_DOWN  = 2'd2;
  localparam dir_t DIR_LEFT  = 2'd3;

  // Opposite heading: flipping bit 1 maps up<->down and right<->left.
  function automatic dir_t dir_reverse(input dir_t d);
    return d ^ DIR_DOWN;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with flush, occupancy count and head/tail peek.
// DEPTH must be a power of two so the pointers wrap on their own.
module sync_fifo #(
  parameter int unsigned WIDTH = 2,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           head,
  output logic [WIDTH-1:0]           tail,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];
  assign tail  = mem_q[wr_ptr_q - PTR_W'(1)];

  // Pointer and occupancy next-state; flush wins over push/pop.
  always_comb begin
    do_push  = push && !full && !flush;
    do_pop   = pop && !empty && !flush;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care until counted as valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/turn_buffer.sv
// Turn buffer: filters keyboard direction commands (no repeats, no reversals)
// and queues them so one is applied per game step.
// Optional macro TURN_BUFFER_DROP_COUNT_EN builds a saturating rejected-command counter.
module turn_buffer
  import snake_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [1:0]                 key_dir,
  input  logic                       key_valid,
  input  logic                       step,
  output logic [1:0]                 snake_dir,
  output logic                       turned,
  output logic [$clog2(DEPTH+1)-1:0] pending,
  output logic [7:0]                 dropped
);

  dir_t snake_dir_q, snake_dir_d;
  logic turned_q, turned_d;
  dir_t head;
  dir_t tail;
  dir_t ref_dir;
  logic full;
  logic empty;
  logic accept;
  logic do_push;
  logic do_pop;

  sync_fifo #(
    .WIDTH (DIR_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (do_push),
    .pop   (do_pop),
    .flush (start),
    .wdata (key_dir),
    .head  (head),
    .tail  (tail),
    .full  (full),
    .empty (empty),
    .count (pending)
  );

  // Filter against the newest queued heading (or the live one) and decide push/pop.
  always_comb begin
    ref_dir     = empty ? snake_dir_q : tail;
    accept      = key_valid && !full && (key_dir != ref_dir) &&
                  (key_dir != dir_reverse(ref_dir));
    do_push     = accept && !start;
    do_pop      = step && !empty && !start;
    snake_dir_d = snake_dir_q;
    turned_d    = 1'b0;
    if (start) begin
      snake_dir_d = DIR_RIGHT;
    end else if (do_pop) begin
      snake_dir_d = head;
      turned_d    = (head != snake_dir_q);
    end
  end

  // Applied heading and turn pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snake_dir_q <= DIR_RIGHT;
      turned_q    <= 1'b0;
    end else begin
      snake_dir_q <= snake_dir_d;
      turned_q    <= turned_d;
    end
  end

  assign snake_dir = snake_dir_q;
  assign turned    = turned_q;

`ifdef TURN_BUFFER_DROP_COUNT_EN
  logic [7:0] dropped_q, dropped_d;
  logic       reject;

  // Saturating count of filtered-out commands; a new game clears it.
  always_comb begin
    reject    = key_valid && !accept;
    dropped_d = dropped_q;
    if (start) begin
      dropped_d = 8'd0;
    end else if (reject && (dropped_q != 8'hFF)) begin
      dropped_d = dropped_q + 8'd1;
    end
  end

  // Drop counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) dropped_q <= 8'd0;
    else     dropped_q <= dropped_d;
  end

  assign dropped = dropped_q;
`else
  assign dropped = 8'd0;
`endif

endmodule
